uncached_dbus_ctrl: RTL and testbench
=====================================

Name: uncached_dbus_ctrl

Overview:
Sequencer for uncached load/store accesses from the MEM stage onto the SRAM-like data bus (req/addr_ok/data_ok). It latches the access, issues one bus transaction, generates dm_stall to freeze the pipeline until completion, and holds load data until the pipeline takes it. It replaces the purely combinational uncached stall term with a real one-outstanding FSM.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
MAX_POST, 2, max posted writes outstanding (only with UNCACHED_POST_WR_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mem_read  in  1  MEM-stage uncached load (lb/lbu/lh/lhu/lw)
mem_write  in  1  MEM-stage uncached store (sb/sh/sw)
mem_size  in  2  0=byte, 1=half, 2=word
mem_addr  in  ADDR_W  access address
mem_wdata  in  DATA_W  store data, lane-aligned
flush  in  1  MEM-stage instruction killed (exception/eret)
pipe_hold  in  1  pipeline frozen by another source this cycle
dm_stall  out  1  freeze pipeline
rdata_out  out  DATA_W  load result, valid while in DONE
data_sram_req  out  1  bus request
data_sram_wr  out  1  1=write
data_sram_size  out  2  latched mem_size
data_sram_addr  out  ADDR_W  latched mem_addr
data_sram_wdata  out  DATA_W  latched mem_wdata
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  transaction finished
data_sram_rdata  in  DATA_W  read data, valid with data_ok

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (async, immediate): state=IDLE, killed=0; all registered outputs (req, wr, size, addr, wdata, rdata_out) = 0.
- dm_stall (combinational) = (IDLE & (mem_read|mem_write) & !flush) | REQ | WAIT. 0 in DONE and during reset.
- IDLE: if (mem_read|mem_write) & !flush: latch wr=mem_write, size, addr, wdata; -> REQ. mem_read & mem_write together: treated as write. flush in IDLE: no start, no stall.
- REQ: data_sram_req=1, bus fields stable. addr_ok -> WAIT, req deasserted the next cycle. req is never withdrawn before addr_ok. data_ok in REQ ignored (protocol violation).
- WAIT: req=0. data_ok -> capture data_sram_rdata into rdata_out (reads only; writes leave rdata_out unchanged) -> DONE, or -> IDLE if killed.
- flush in REQ/WAIT: set killed; transaction runs to completion, result discarded, no DONE cycle; killed cleared on leaving WAIT.
- DONE: dm_stall=0, rdata_out held. pipe_hold=1 -> stay in DONE (same instruction must not reissue); else -> IDLE next cycle. A new access is therefore accepted no earlier than the cycle after DONE.
- Minimum latency, addr_ok in the first REQ cycle and data_ok one cycle later: access seen (IDLE) -> REQ -> WAIT -> DONE = 3 stall cycles, released in cycle 4.
- Reset mid-transaction: abandons the access. The bus slave is reset by the same rst.

Optional Feature:
UNCACHED_POST_WR_EN
- Defined: writes leave REQ on addr_ok directly to DONE and skip WAIT. pend counter (width clog2(MAX_POST+1)) +1 on write addr_ok, -1 on data_ok while not in a read WAIT; simultaneous inc/dec leaves it unchanged.
- A write waits in IDLE (stalled) while pend==MAX_POST. A read waits in IDLE (stalled) until pend==0, so the next data_ok belongs to the read.
- flush never affects already-posted writes.
- Not defined: no counter; writes wait for data_ok exactly like reads.

Test Plan:
- lw addr 0x1FAF_0000, addr_ok cycle 1, data_ok cycle 3 with rdata 0xDEAD_BEEF -> req high exactly one cycle, dm_stall high 4 cycles, rdata_out=0xDEAD_BEEF in DONE.
- sb addr 0xBFD0_0003 wdata 0x0000_00AA, addr_ok delayed 5 cycles -> req, wr=1, size=0, addr, wdata all stable for 6 cycles; single transaction.
- flush asserted during WAIT of lw -> no DONE cycle, rdata_out unchanged, dm_stall drops the cycle after data_ok, no reissue.
- DONE with pipe_hold=1 for 3 cycles -> state stays DONE, req stays 0, rdata_out stable; one bus transaction total.
- rst pulsed while in REQ -> req=0 and dm_stall=0 asynchronously; next lw starts cleanly from IDLE.
- UNCACHED_POST_WR_EN, MAX_POST=2: sw, sw, sw with data_ok withheld -> third sw stalls in IDLE until first data_ok; following lw stalls until pend==0.

Source files
------------

// File: rtl/uncached_dbus_ctrl.sv
// One-outstanding uncached load/store sequencer onto the SRAM-like data bus; dm_stall held from acceptance to completion (min 3 cycles).
// Bus fields are held until addr_ok. `define UNCACHED_POST_WR_EN lets writes retire on addr_ok, with up to MAX_POST of them left posted.
module uncached_dbus_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_POST = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              flush,
   input  logic              pipe_hold,
   output logic              dm_stall,
   output logic [DATA_W-1:0] rdata_out,
   output logic              data_sram_req,
   output logic              data_sram_wr,
   output logic [1:0]        data_sram_size,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [DATA_W-1:0] data_sram_wdata,
   input  logic              data_sram_addr_ok,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic              r_killed;
   logic              r_req;
   logic              r_wr;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic w_access;
   logic w_can_start;
   logic w_kill;

   assign w_access = (mem_read | mem_write) & ~flush;
   // A flush arriving in the same cycle as the response still discards it.
   assign w_kill   = r_killed | flush;

`ifdef UNCACHED_POST_WR_EN
   localparam int PEND_W = $clog2(MAX_POST + 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POST);

   logic [PEND_W-1:0] r_pend;
   logic              w_pend_inc;
   logic              w_pend_dec;

   assign w_pend_inc = (r_state == S_REQ) & r_wr & data_sram_addr_ok;
   // Posted writes never occupy WAIT, so any data_ok seen outside WAIT retires one.
   assign w_pend_dec = data_sram_data_ok & (r_state != S_WAIT);
   assign w_can_start = mem_write ? (r_pend != PEND_MAX) : (r_pend == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         case ({w_pend_inc, w_pend_dec})
            2'b10:   r_pend <= r_pend + 1'b1;
            2'b01:   r_pend <= r_pend - 1'b1;
            default: r_pend <= r_pend;
         endcase
      end
   end
`else
   localparam int unused_max_post = MAX_POST;
   assign w_can_start = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_killed <= 1'b0;
         r_req    <= 1'b0;
         r_wr     <= 1'b0;
         r_size   <= 2'd0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access && w_can_start) begin
                  r_wr    <= mem_write;
                  r_size  <= mem_size;
                  r_addr  <= mem_addr;
                  r_wdata <= mem_wdata;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (flush) r_killed <= 1'b1;
               if (data_sram_addr_ok) begin
                  r_req <= 1'b0;
`ifdef UNCACHED_POST_WR_EN
                  if (r_wr) begin
                     r_killed <= 1'b0;
                     r_state  <= w_kill ? S_IDLE : S_DONE;
                  end else begin
                     r_state  <= S_WAIT;
                  end
`else
                  r_state <= S_WAIT;
`endif
               end
            end
            S_WAIT: begin
               if (flush) r_killed <= 1'b1;
               if (data_sram_data_ok) begin
                  r_killed <= 1'b0;
                  if (w_kill) begin
                     r_state <= S_IDLE;
                  end else begin
                     if (!r_wr) r_rdata <= data_sram_rdata;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // Holding here keeps the still-present MEM instruction from reissuing.
               if (!pipe_hold) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dm_stall = ~rst & (((r_state == S_IDLE) & w_access) |
                             (r_state == S_REQ) | (r_state == S_WAIT));

   assign rdata_out       = r_rdata;
   assign data_sram_req   = r_req;
   assign data_sram_wr    = r_wr;
   assign data_sram_size  = r_size;
   assign data_sram_addr  = r_addr;
   assign data_sram_wdata = r_wdata;

endmodule

// File: tb/tb_uncached_dbus_ctrl.sv
// Directed bench for uncached_dbus_ctrl: drives the bus handshake by hand and checks stall, request and load data per cycle.
// The posted-write sequence runs only when UNCACHED_POST_WR_EN is defined.
module tb_uncached_dbus_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic [1:0]        mem_size = 2'd0;
   logic [ADDR_W-1:0] mem_addr = '0;
   logic [DATA_W-1:0] mem_wdata = '0;
   logic              flush = 1'b0;
   logic              pipe_hold = 1'b0;
   logic              dm_stall;
   logic [DATA_W-1:0] rdata_out;
   logic              data_sram_req;
   logic              data_sram_wr;
   logic [1:0]        data_sram_size;
   logic [ADDR_W-1:0] data_sram_addr;
   logic [DATA_W-1:0] data_sram_wdata;
   logic              data_sram_addr_ok = 1'b0;
   logic              data_sram_data_ok = 1'b0;
   logic [DATA_W-1:0] data_sram_rdata = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_txn   = 0;
   int t0;
   int stalls;
   int reqs;
   int bad;

   uncached_dbus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_POST(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_size          (mem_size),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .flush             (flush),
      .pipe_hold         (pipe_hold),
      .dm_stall          (dm_stall),
      .rdata_out         (rdata_out),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata)
   );

   always #5 clk = ~clk;

   // Accepted bus transactions.
   always @(posedge clk) begin
      if (!rst && data_sram_req && data_sram_addr_ok) n_txn <= n_txn + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst_req",   data_sram_req,   0);
      check("rst_wr",    data_sram_wr,    0);
      check("rst_addr",  data_sram_addr,  0);
      check("rst_wdata", data_sram_wdata, 0);
      check("rst_rdata", rdata_out,       0);
      check("rst_stall", dm_stall,        0);
      rst = 1'b0;
      cyc; cyc;

      // lw, addr_ok in first REQ cycle, data_ok two cycles later
      mem_read = 1; mem_size = 2; mem_addr = 32'h1FAF_0000; #1;
      check("t1_stall_seen", dm_stall, 1);
      stalls = 1; reqs = 0; t0 = n_txn;
      cyc; data_sram_addr_ok = 1; #1;
      check("t1_req", data_sram_req, 1);
      check("t1_addr", data_sram_addr, 32'h1FAF_0000);
      stalls += dm_stall; reqs += data_sram_req;
      cyc; data_sram_addr_ok = 0; #1;
      stalls += dm_stall; reqs += data_sram_req;
      cyc; data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF; #1;
      stalls += dm_stall; reqs += data_sram_req;
      cyc; data_sram_data_ok = 0; data_sram_rdata = 0; #1;
      check("t1_stall_done", dm_stall, 0);
      check("t1_rdata", rdata_out, 32'hDEAD_BEEF);
      check("t1_stall_cycles", stalls, 4);
      check("t1_req_cycles", reqs, 1);
      cyc; mem_read = 0; #1;
      check("t1_idle_stall", dm_stall, 0);
      check("t1_txn", n_txn - t0, 1);

`ifndef UNCACHED_POST_WR_EN
      // sb with addr_ok delayed 5 cycles; MEM inputs wiggle to prove the bus fields are latched
      mem_write = 1; mem_size = 0; mem_addr = 32'hBFD0_0003; mem_wdata = 32'h0000_00AA; #1;
      check("t2_stall_seen", dm_stall, 1);
      t0 = n_txn; reqs = 0; bad = 0;
      for (int i = 0; i < 6; i++) begin
         cyc;
         data_sram_addr_ok = (i == 5);
         mem_addr = 32'h0000_1000 + i; mem_wdata = 32'h55 + i;
         #1;
         reqs += data_sram_req;
         if (data_sram_req !== 1'b1 || data_sram_wr !== 1'b1 || data_sram_size !== 2'd0 ||
             data_sram_addr !== 32'hBFD0_0003 || data_sram_wdata !== 32'h0000_00AA) bad++;
      end
      check("t2_req_cycles", reqs, 6);
      check("t2_fields_stable", bad, 0);
      cyc; data_sram_addr_ok = 0; data_sram_data_ok = 1; #1;
      check("t2_req_wait", data_sram_req, 0);
      check("t2_stall_wait", dm_stall, 1);
      cyc; data_sram_data_ok = 0; #1;
      check("t2_stall_done", dm_stall, 0);
      check("t2_rdata_kept", rdata_out, 32'hDEAD_BEEF);
      cyc; mem_write = 0; #1;
      check("t2_txn", n_txn - t0, 1);
`endif

      // flush during WAIT of lw
      mem_read = 1; mem_size = 2; mem_addr = 32'h1FAF_0004; #1;
      t0 = n_txn;
      cyc; data_sram_addr_ok = 1; #1;
      cyc; data_sram_addr_ok = 0; flush = 1; #1;
      check("t3_stall_flush", dm_stall, 1);
      cyc; flush = 0; mem_read = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678; #1;
      check("t3_stall_dataok", dm_stall, 1);
      cyc; data_sram_data_ok = 0; data_sram_rdata = 0; #1;
      check("t3_stall_after", dm_stall, 0);
      check("t3_rdata_kept", rdata_out, 32'hDEAD_BEEF);
      cyc; #1;
      check("t3_no_reissue", data_sram_req, 0);
      check("t3_txn", n_txn - t0, 1);

      // minimum latency lw, then DONE held by pipe_hold for 3 cycles
      mem_read = 1; mem_size = 2; mem_addr = 32'h1FAF_0008; #1;
      stalls = dm_stall; t0 = n_txn;
      cyc; data_sram_addr_ok = 1; #1; stalls += dm_stall;
      cyc; data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D; #1;
      stalls += dm_stall;
      cyc; data_sram_data_ok = 0; data_sram_rdata = 0; pipe_hold = 1; #1;
      check("t4_min_latency", stalls, 3);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (dm_stall !== 1'b0 || data_sram_req !== 1'b0 || rdata_out !== 32'hCAFE_F00D) bad++;
         cyc;
      end
      pipe_hold = 0; #1;
      check("t4_hold_stable", bad, 0);
      check("t4_hold_release_stall", dm_stall, 0);
      cyc; mem_read = 0; #1;
      check("t4_txn", n_txn - t0, 1);

      // flush in IDLE: no stall, no start
      mem_read = 1; flush = 1; mem_addr = 32'h1FAF_000C; #1;
      check("fl_idle_stall", dm_stall, 0);
      cyc; flush = 0; mem_read = 0; #1;
      check("fl_idle_no_req", data_sram_req, 0);

      // read and write together count as a write
      mem_read = 1; mem_write = 1; mem_size = 2; mem_addr = 32'h1FAF_0010; mem_wdata = 32'h1122_3344; #1;
      cyc; data_sram_addr_ok = 1; #1;
      check("rw_is_write", data_sram_wr, 1);
      check("rw_wdata", data_sram_wdata, 32'h1122_3344);
      cyc; data_sram_addr_ok = 0; data_sram_data_ok = 1; #1;
      cyc; data_sram_data_ok = 0; mem_read = 0; mem_write = 0; #1;
      cyc; cyc;
      check("rw_rdata_kept", rdata_out, 32'hCAFE_F00D);

      // reset pulsed while in REQ
      mem_read = 1; mem_size = 2; mem_addr = 32'h1FAF_000C; #1;
      cyc; #1;
      check("t5_req_before", data_sram_req, 1);
      rst = 1; #1;
      check("t5_rst_req", data_sram_req, 0);
      check("t5_rst_stall", dm_stall, 0);
      check("t5_rst_rdata", rdata_out, 0);
      #2 rst = 0; #1;
      cyc; data_sram_addr_ok = 1; #1;
      check("t5_restart_req", data_sram_req, 1);
      check("t5_restart_addr", data_sram_addr, 32'h1FAF_000C);
      cyc; data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h0BAD_C0DE; #1;
      cyc; data_sram_data_ok = 0; data_sram_rdata = 0; #1;
      check("t5_rdata", rdata_out, 32'h0BAD_C0DE);
      check("t5_stall_done", dm_stall, 0);
      cyc; mem_read = 0; #1;

`ifdef UNCACHED_POST_WR_EN
      // three posted sw with data_ok withheld, then a lw that must drain them
      mem_write = 1; mem_size = 2; mem_addr = 32'hBFD0_0100; mem_wdata = 32'h1; #1;
      cyc; data_sram_addr_ok = 1; #1;
      check("p_a_req", data_sram_req, 1);
      cyc; data_sram_addr_ok = 0; #1;
      check("p_a_done", dm_stall, 0);
      cyc; mem_addr = 32'hBFD0_0104; mem_wdata = 32'h2; #1;
      cyc; data_sram_addr_ok = 1; #1;
      check("p_b_req", data_sram_req, 1);
      cyc; data_sram_addr_ok = 0; #1;
      check("p_b_done", dm_stall, 0);
      cyc; mem_addr = 32'hBFD0_0108; mem_wdata = 32'h3; #1;
      check("p_c_blocked_stall", dm_stall, 1);
      cyc; data_sram_data_ok = 1; #1;
      check("p_c_blocked_req0", data_sram_req, 0);
      cyc; data_sram_data_ok = 0; #1;
      check("p_c_blocked_req1", data_sram_req, 0);
      cyc; data_sram_addr_ok = 1; #1;
      check("p_c_req", data_sram_req, 1);
      check("p_c_addr", data_sram_addr, 32'hBFD0_0108);
      cyc; data_sram_addr_ok = 0; #1;
      cyc; mem_write = 0; mem_read = 1; mem_addr = 32'h1FAF_0020; #1;
      check("p_r_stall", dm_stall, 1);
      cyc; data_sram_data_ok = 1; #1;
      check("p_r_wait0", data_sram_req, 0);
      cyc; #1;
      check("p_r_wait1", data_sram_req, 0);
      cyc; data_sram_data_ok = 0; #1;
      check("p_r_wait2", data_sram_req, 0);
      check("p_r_wait2_stall", dm_stall, 1);
      cyc; data_sram_addr_ok = 1; #1;
      check("p_r_req", data_sram_req, 1);
      cyc; data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hA5A5_A5A5; #1;
      cyc; data_sram_data_ok = 0; data_sram_rdata = 0; #1;
      check("p_r_rdata", rdata_out, 32'hA5A5_A5A5);
      check("p_r_done", dm_stall, 0);
      cyc; mem_read = 0; #1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
